// File: rtl/soc_system_pio_in_capture.sv
// Avalon-MM input PIO: synchronised, debounced inputs with edge capture,
// maskable level interrupt and a saturating event counter.
module soc_system_pio_in_capture #(
  parameter int unsigned WIDTH           = 8,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 0,
  parameter int unsigned EDGE_MODE       = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam int unsigned CNT_W        = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned BLANK_CYCLES = SYNC_STAGES + DEBOUNCE_CYCLES + 1;
  localparam int unsigned BLANK_W      = $clog2(BLANK_CYCLES + 1);
  localparam int unsigned EVT_W        = 16;

  logic [WIDTH-1:0]   sync_q [SYNC_STAGES];
  logic [WIDTH-1:0]   sync_out;
  logic [WIDTH-1:0]   stable;
  logic [CNT_W-1:0]   cnt [WIDTH];
  logic [BLANK_W-1:0] blank_cnt;
  logic [WIDTH-1:0]   edge_capture;
  logic [WIDTH-1:0]   irq_mask;
  logic [EVT_W-1:0]   event_count;
  logic [WIDTH-1:0]   update;
  logic [WIDTH-1:0]   edge_det;
  logic [WIDTH-1:0]   w1c;
  logic [31:0]        rd_mux;
  logic               blanking;
  logic               wr_en;
  logic               event_hit;
  logic               unused_wdata;

  assign sync_out     = sync_q[SYNC_STAGES-1];
  assign blanking     = (blank_cnt != BLANK_W'(BLANK_CYCLES));
  assign wr_en        = chipselect & ~write_n;
  assign w1c          = (wr_en && address == 2'd1) ? writedata[WIDTH-1:0] : '0;
  assign event_hit    = |edge_det;
  assign irq          = |(edge_capture & irq_mask);
  assign unused_wdata = ^writedata;

  // Per-bit debounce qualification and edge classification
  always_comb begin
    update   = '0;
    edge_det = '0;
    for (int i = 0; i < WIDTH; i++) begin
      update[i] = (sync_out[i] != stable[i]) && (cnt[i] == CNT_W'(DEBOUNCE_CYCLES));
    end
    if (EDGE_MODE == 0) begin
      edge_det = ~stable & sync_out & update;
    end else if (EDGE_MODE == 1) begin
      edge_det = stable & ~sync_out & update;
    end else begin
      edge_det = update;
    end
    if (blanking) begin
      edge_det = '0;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      2'd0:    rd_mux = 32'(stable);
      2'd1:    rd_mux = 32'(edge_capture);
      2'd2:    rd_mux = 32'(irq_mask);
      default: rd_mux = 32'(event_count);
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
      stable       <= '0;
      blank_cnt    <= '0;
      edge_capture <= '0;
      irq_mask     <= '0;
      event_count  <= '0;
      readdata     <= '0;
    end else begin
      sync_q[0] <= in_port;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];

      // Right after reset the stable value follows the inputs without debounce
      if (blanking) begin
        stable    <= sync_out;
        blank_cnt <= blank_cnt + BLANK_W'(1);
        for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
      end else begin
        stable <= (stable & ~update) | (sync_out & update);
        for (int i = 0; i < WIDTH; i++) begin
          if (sync_out[i] == stable[i] || update[i]) cnt[i] <= '0;
          else                                       cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end

      // A coincident edge overrides the write-1-to-clear
      edge_capture <= (edge_capture & ~w1c) | edge_det;

      if (wr_en && address == 2'd2) irq_mask <= writedata[WIDTH-1:0];

      if (wr_en && address == 2'd3) begin
        event_count <= event_hit ? EVT_W'(1) : '0;
      end else if (event_hit && event_count != {EVT_W{1'b1}}) begin
        event_count <= event_count + EVT_W'(1);
      end

      readdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_soc_system_pio_in_capture.sv
// Directed bench for soc_system_pio_in_capture: three instances cover
// rising/no-debounce, rising/debounce-4 and any-edge configurations.
module tb_soc_system_pio_in_capture;

  logic        clk;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [7:0]  in_port_a, in_port_b, in_port_c;
  logic [31:0] rd_a, rd_b, rd_c;
  logic        irq_a, irq_b, irq_c;

  int n_vec = 0;
  int n_err = 0;

  soc_system_pio_in_capture #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0), .EDGE_MODE(0)) u_a (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .readdata(rd_a), .in_port(in_port_a), .irq(irq_a));

  soc_system_pio_in_capture #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_MODE(0)) u_b (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .readdata(rd_b), .in_port(in_port_b), .irq(irq_b));

  soc_system_pio_in_capture #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0), .EDGE_MODE(2)) u_c (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .readdata(rd_c), .in_port(in_port_c), .irq(irq_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [1:0] a);
    address = a;
    tick();
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  initial begin
    reset      = 1'b1;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in_port_a  = 8'h00;
    in_port_b  = 8'h00;
    in_port_c  = 8'h00;
    tick();
    tick();
    chk("reset_rd_a", rd_a, 32'h0);
    chk("reset_irq_a", {31'b0, irq_a}, 32'h0);

    // Inputs present while reset releases: blanking absorbs them silently
    in_port_a = 8'hA5;
    reset     = 1'b0;
    repeat (8) tick();
    rd(2'd0); chk("a_data_a5", rd_a, 32'h0000_00A5);
    rd(2'd1); chk("a_cap_blank", rd_a, 32'h0);
    rd(2'd3); chk("a_evt_blank", rd_a, 32'h0);
    chk("a_irq_blank", {31'b0, irq_a}, 32'h0);
    wr(2'd0, 32'hFFFF_FFFF);
    rd(2'd0); chk("a_data_ro", rd_a, 32'h0000_00A5);

    // Falling edges are ignored in rising mode
    wr(2'd2, 32'h0000_0001);
    rd(2'd2); chk("a_mask_rb", rd_a, 32'h0000_0001);
    in_port_a = 8'h00;
    repeat (4) tick();
    rd(2'd1); chk("a_cap_fall", rd_a, 32'h0);

    // 0x00 -> 0x01: stable/irq at edge 2, readdata at edge 3
    address   = 2'd0;
    in_port_a = 8'h01;
    tick();
    tick(); chk("a_irq_e1", {31'b0, irq_a}, 32'h0);
    tick(); chk("a_irq_e2", {31'b0, irq_a}, 32'h1);
            chk("a_rd_e2", rd_a, 32'h0);
    tick(); chk("a_rd_e3", rd_a, 32'h0000_0001);
    rd(2'd1); chk("a_cap_rise", rd_a, 32'h0000_0001);
    wr(2'd1, 32'h0000_0001);
    chk("a_irq_w1c", {31'b0, irq_a}, 32'h0);
    rd(2'd1); chk("a_cap_cleared", rd_a, 32'h0);
    rd(2'd3); chk("a_evt_one", rd_a, 32'h0000_0001);

    // Debounce 4: a 3-cycle glitch is rejected
    in_port_b = 8'h08;
    repeat (3) tick();
    in_port_b = 8'h00;
    repeat (8) tick();
    rd(2'd0); chk("b_glitch_data", rd_b, 32'h0);
    rd(2'd1); chk("b_glitch_cap", rd_b, 32'h0);

    // 10-cycle pulse: stable at edge 6, readdata at edge 7
    address   = 2'd0;
    in_port_b = 8'h08;
    repeat (7) tick(); chk("b_rd_e6", rd_b, 32'h0);
    tick();            chk("b_rd_e7", rd_b, 32'h0000_0008);
    repeat (2) tick();
    in_port_b = 8'h00;
    repeat (10) tick();
    rd(2'd3); chk("b_evt_one", rd_b, 32'h0000_0001);
    rd(2'd1); chk("b_cap_bit3", rd_b, 32'h0000_0008);
    chk("b_irq_masked", {31'b0, irq_b}, 32'h0);

    // Any-edge mode: two bits toggling together make one event
    in_port_c = 8'h03;
    repeat (4) tick();
    rd(2'd1); chk("c_cap_03", rd_c, 32'h0000_0003);
    rd(2'd3); chk("c_evt_one", rd_c, 32'h0000_0001);
    chk("c_irq_set", {31'b0, irq_c}, 32'h1);

    // W1C of bit 0 on the same edge bit 0 changes: the edge wins
    in_port_c = 8'h02;
    tick();
    tick();
    wr(2'd1, 32'h0000_0001);
    rd(2'd1); chk("c_w1c_vs_edge", rd_c, 32'h0000_0003);

    // EVENT_COUNT clear on the same edge as an event reads 1
    in_port_c = 8'h00;
    tick();
    tick();
    wr(2'd3, 32'h0);
    rd(2'd3); chk("c_clr_vs_evt", rd_c, 32'h0000_0001);

    // Saturation at 0xFFFF
    for (int k = 0; k < 70000; k++) begin
      in_port_c = in_port_c ^ 8'h01;
      tick();
    end
    repeat (4) tick();
    rd(2'd3); chk("c_evt_sat", rd_c, 32'h0000_FFFF);
    for (int k = 0; k < 10; k++) begin
      in_port_c = in_port_c ^ 8'h01;
      tick();
    end
    repeat (4) tick();
    rd(2'd3); chk("c_evt_hold", rd_c, 32'h0000_FFFF);
    chk("c_irq_pre_rst", {31'b0, irq_c}, 32'h1);

    // Reset mid-stream
    for (int k = 0; k < 5; k++) begin
      in_port_c = in_port_c ^ 8'h01;
      tick();
    end
    reset     = 1'b1;
    in_port_c = in_port_c ^ 8'h01;
    tick();
    chk("rst_rd_c", rd_c, 32'h0);
    chk("rst_irq_c", {31'b0, irq_c}, 32'h0);
    chk("rst_rd_b", rd_b, 32'h0);
    chk("rst_irq_a", {31'b0, irq_a}, 32'h0);
    in_port_c = 8'h00;
    reset     = 1'b0;
    repeat (10) tick();
    rd(2'd1); chk("post_cap_c", rd_c, 32'h0);
              chk("post_cap_a", rd_a, 32'h0);
    rd(2'd2); chk("post_mask_c", rd_c, 32'h0);
    rd(2'd3); chk("post_evt_c", rd_c, 32'h0);
              chk("post_evt_b", rd_b, 32'h0);
    rd(2'd0); chk("post_data_a", rd_a, 32'h0000_0001);
              chk("post_data_b", rd_b, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
